// File: rtl/thirtytwo_to_five_encoder_if.sv
// Request-vector in / binary-index out handshake bundle for the 32-to-5 encoder.
interface thirtytwo_to_five_encoder_if;
   localparam int unsigned N  = 32;
   localparam int unsigned W  = 5;
   localparam int unsigned CW = 6;

   logic [N-1:0]  in;
   logic          en;
   logic          in_ready;
   logic [W-1:0]  out;
   logic          out_valid;
   logic          out_ready;
   logic [CW-1:0] count;
   logic          done;
   logic          zero;

   // Producer/consumer side (drives the vector and accepts indices).
   modport master (
      output in, en, out_ready,
      input  in_ready, out, out_valid, count, done, zero
   );

   // Encoder side.
   modport slave (
      input  in, en, out_ready,
      output in_ready, out, out_valid, count, done, zero
   );
endinterface

// File: rtl/thirtytwo_to_five_encoder.sv
// Captures a 32-bit multi-hot request vector and emits the index of each set
// bit, lowest first, one index per out_valid/out_ready handshake.
module thirtytwo_to_five_encoder (
   input logic                         clk,
   input logic                         rst,
   thirtytwo_to_five_encoder_if.slave  bus
);
   localparam int unsigned N  = 32;
   localparam int unsigned W  = 5;
   localparam int unsigned CW = 6;

   typedef enum logic {
      IDLE  = 1'b0,
      DRAIN = 1'b1
   } state_t;

   state_t        state;
   logic [N-1:0]  pending;
   logic [CW-1:0] count_q;
   logic [W-1:0]  out_q;
   logic          out_valid_q;
   logic          in_ready_q;
   logic          done_q;
   logic          zero_q;

   logic [N-1:0]  cleared;
   logic [W-1:0]  lo_in;
   logic [W-1:0]  lo_cleared;
   logic [CW-1:0] pop_in;

   // Index of the lowest set bit; 0 for an all-zero vector.
   function automatic logic [W-1:0] lowest_index(input logic [N-1:0] v);
      logic [W-1:0] idx;
      idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (v[i]) idx = W'(i);
      end
      return idx;
   endfunction

   // Number of set bits (0..32 fits in CW bits).
   function automatic logic [CW-1:0] popcount(input logic [N-1:0] v);
      logic [CW-1:0] c;
      c = '0;
      for (int i = 0; i < N; i++) begin
         c = c + CW'(v[i]);
      end
      return c;
   endfunction

   // Next-index lookahead so out can be registered: pending with its lowest bit removed.
   always_comb begin
      cleared    = pending & (pending - N'(1));
      lo_in      = lowest_index(bus.in);
      lo_cleared = lowest_index(cleared);
      pop_in     = popcount(bus.in);
   end

   // Capture/drain state machine with registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         pending     <= '0;
         count_q     <= '0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
         done_q      <= 1'b0;
         zero_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         zero_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.en) begin
                  pending <= bus.in;
                  count_q <= pop_in;
                  if (bus.in != '0) begin
                     state       <= DRAIN;
                     out_q       <= lo_in;
                     out_valid_q <= 1'b1;
                     in_ready_q  <= 1'b0;
                  end else begin
                     zero_q <= 1'b1;
                  end
               end
            end
            DRAIN: begin
               if (bus.out_ready) begin
                  pending <= cleared;
                  if (cleared == '0) begin
                     state       <= IDLE;
                     out_q       <= '0;
                     out_valid_q <= 1'b0;
                     in_ready_q  <= 1'b1;
                     done_q      <= 1'b1;
                  end else begin
                     out_q <= lo_cleared;
                  end
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.out       = out_q;
   assign bus.out_valid = out_valid_q;
   assign bus.in_ready  = in_ready_q;
   assign bus.count     = count_q;
   assign bus.done      = done_q;
   assign bus.zero      = zero_q;

endmodule
